// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared video definitions for the DVI TMDS encoder: symbol width, control
// tokens and small helpers used by both pipeline stages.
package dvi_tmds_encoder_pkg;

  localparam int TMDS_W = 10;

  typedef logic [TMDS_W-1:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_TOKEN_00 = 10'h354;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'h0AB;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'h154;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'h2AB;

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    unique case (c)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/dvi_tmds_encoder_channel.sv
// One TMDS channel: stage 1 builds the transition-minimised q_m word,
// stage 2 applies DC balancing or substitutes a control token.
module tmds_encode_channel
  import dvi_tmds_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       den,
  input  logic [1:0] c,
  input  logic [7:0] d,
  output tmds_sym_t  q
);

  logic [8:0]        q_m_nxt;
  logic [8:0]        q_m_s1;
  logic              den_s1;
  logic [1:0]        c_s1;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic signed [4:0] diff;
  logic [3:0]        n1d;
  logic [3:0]        n1;
  logic              use_xnor;
  tmds_sym_t         q_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q_m_nxt  = '0;
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q_m_nxt[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q_m_nxt[i] = use_xnor ? ~(q_m_nxt[i-1] ^ d[i]) : (q_m_nxt[i-1] ^ d[i]);
    end
    q_m_nxt[8] = ~use_xnor;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      den_s1 <= 1'b0;
      c_s1   <= 2'b00;
      q_m_s1 <= '0;
    end else begin
      den_s1 <= en & den;
      c_s1   <= en ? c : 2'b00;
      q_m_s1 <= q_m_nxt;
    end
  end

  // diff = N1 - N0 = 2*N1 - 8, which always fits in 5 signed bits.
  always_comb begin
    n1      = popcount8(q_m_s1[7:0]);
    diff    = $signed({n1, 1'b0}) - 5'sd8;
    q_nxt   = CTRL_TOKEN_00;
    cnt_nxt = cnt;
    if (!den_s1) begin
      q_nxt   = ctrl_token(c_s1);
      cnt_nxt = '0;
    end else if ((cnt == '0) || (diff == '0)) begin
      q_nxt   = {~q_m_s1[8], q_m_s1[8], q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
      cnt_nxt = q_m_s1[8] ? (cnt + diff) : (cnt - diff);
    end else if (cnt[4] == diff[4]) begin
      // Both nonzero here, so equal sign bits mean the disparity would grow.
      q_nxt   = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
      cnt_nxt = cnt + (q_m_s1[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      q_nxt   = {1'b0, q_m_s1[8], q_m_s1[7:0]};
      cnt_nxt = cnt - (q_m_s1[8] ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= CTRL_TOKEN_00;
      cnt <= '0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: three identical channel encoders; only channel 0
// carries the sync pair as its control input.
module dvi_tmds_encoder
  import dvi_tmds_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              den,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic [TMDS_W-1:0] tmds0,
  output logic [TMDS_W-1:0] tmds1,
  output logic [TMDS_W-1:0] tmds2
);

  tmds_encode_channel u_ch0 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .den (den),
    .c   ({vsync, hsync}),
    .d   (b),
    .q   (tmds0)
  );

  tmds_encode_channel u_ch1 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .den (den),
    .c   (2'b00),
    .d   (g),
    .q   (tmds1)
  );

  tmds_encode_channel u_ch2 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .den (den),
    .c   (2'b00),
    .d   (r),
    .q   (tmds2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: directed vector table plus a
// randomised run against an independent DVI 1.0 encoder model.
module tb_dvi_tmds_encoder;

  typedef struct {
    logic       rst, en, den, hs, vs;
    logic [7:0] r, g, b;
    logic [9:0] e0, e1, e2;
  } vec_t;

  typedef struct {
    logic [9:0] s0, s1, s2;
    logic       den;
    logic [7:0] r, g, b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, den, hsync, vsync;
  logic [7:0] r, g, b;
  logic [9:0] tmds0, tmds1, tmds2;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt_viol = 0;
  bit   mon_on   = 1'b0;
  vec_t vecs[$];
  exp_t sb[$];
  int   m_cnt[3];

  dvi_tmds_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .den   (den),
    .hsync (hsync),
    .vsync (vsync),
    .r     (r),
    .g     (g),
    .b     (b),
    .tmds0 (tmds0),
    .tmds1 (tmds1),
    .tmds2 (tmds2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w;
    logic [7:0] d;
    w = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  function automatic bit out_of_range(input logic signed [4:0] v);
    int x;
    x = int'(v);
    return $isunknown(v) || (x <= -16) || (x >= 16);
  endfunction

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (out_of_range(dut.u_ch0.cnt) || out_of_range(dut.u_ch1.cnt) ||
          out_of_range(dut.u_ch2.cnt))
        cnt_viol++;
    end
  end

  task automatic model_enc(input logic den_i, input logic [1:0] c, input logic [7:0] d,
                           inout int cnt, output logic [9:0] sym);
    int         ones, n1, n0;
    logic       xnr;
    logic [8:0] qm;
    if (!den_i) begin
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      cnt = 0;
      return;
    end
    ones = $countones(d);
    xnr  = (ones > 4) || (ones == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnr ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnr;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      if (qm[8]) begin sym = {2'b01, qm[7:0]};  cnt += n1 - n0; end
      else       begin sym = {2'b10, ~qm[7:0]}; cnt += n0 - n1; end
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt += -2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  task automatic add(input logic rst_i, en_i, den_i, hs, vs, input logic [7:0] rr, gg, bb,
                     input logic [9:0] e0, e1, e2);
    vec_t v;
    v = '{rst: rst_i, en: en_i, den: den_i, hs: hs, vs: vs, r: rr, g: gg, b: bb,
          e0: e0, e1: e1, e2: e2};
    vecs.push_back(v);
  endtask

  // Drive one cycle; the expectation for this input emerges two edges after it is applied.
  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; en = v.en; den = v.den; hsync = v.hs; vsync = v.vs;
    r = v.r; g = v.g; b = v.b;
    @(posedge clk);
    if (v.rst) begin
      e = '{s0: 10'h354, s1: 10'h354, s2: 10'h354, den: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};
      sb.delete();
      sb.push_back(e);
      sb.push_back(e);
    end else begin
      e = '{s0: v.e0, s1: v.e1, s2: v.e2, den: v.en & v.den, r: v.r, g: v.g, b: v.b};
      sb.push_back(e);
    end
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("tmds0", tmds0, e.s0);
      check("tmds1", tmds1, e.s1);
      check("tmds2", tmds2, e.s2);
      if (e.den) begin
        check("decode_b", {2'b00, decode(tmds0)}, {2'b00, e.b});
        check("decode_g", {2'b00, decode(tmds1)}, {2'b00, e.g});
        check("decode_r", {2'b00, decode(tmds2)}, {2'b00, e.r});
      end
    end
  endtask

  task automatic add_zero_pixels(input int n, input bit start_a);
    for (int i = 0; i < n; i++) begin
      if ((i % 2 == 0) == start_a) add(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
      else                         add(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);
    end
  endtask

  task automatic add_idle();
    add(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354);
  endtask

  initial begin
    vec_t       v;
    logic [9:0] s0, s1, s2;

    // Reset with arbitrary inputs, then idle blanking.
    add(1, 1, 1, 1, 1, 8'hAA, 8'h55, 8'hC3, 10'h354, 10'h354, 10'h354);
    add(1, 0, 1, 0, 1, 8'h12, 8'h34, 8'h56, 10'h354, 10'h354, 10'h354);
    repeat (3) add_idle();
    // Sync tokens on channel 0 only.
    add(0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354);
    add_idle();
    add(0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354);
    add(0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354);
    add_idle();
    // Nine all-zero pixels: disparity walks back to zero.
    add_zero_pixels(9, 1'b1);
    add_idle();
    // b=FF for three pixels.
    add(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 10'h200, 10'h100, 10'h100);
    add(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 10'h0FF, 10'h3FF, 10'h3FF);
    add(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 10'h0FF, 10'h100, 10'h100);
    add_idle();
    // Disparity cleared by blanking, by en low, and by a mid-line reset.
    add_zero_pixels(3, 1'b1);
    add_idle();
    add_zero_pixels(1, 1'b1);
    add_idle();
    add_zero_pixels(3, 1'b1);
    add(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354);
    add_zero_pixels(1, 1'b1);
    add_idle();
    add_zero_pixels(3, 1'b1);
    add(1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354);
    add_zero_pixels(1, 1'b1);
    add_idle();
    // den toggling every cycle, with hsync during one blank.
    add_zero_pixels(1, 1'b1);
    add(0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354);
    add_zero_pixels(1, 1'b1);
    add_idle();
    add_zero_pixels(1, 1'b1);
    add_idle();

    foreach (vecs[i]) begin
      step(vecs[i]);
      if (vecs[i].rst) mon_on = 1'b1;
    end

    // Random traffic against the model, starting from a clean reset.
    for (int i = 0; i < 20000; i++) begin
      v.rst = (i == 0) || ($urandom_range(0, 999) == 0);
      v.en  = ($urandom_range(0, 19) != 0);
      v.den = ($urandom_range(0, 3) != 0);
      v.hs  = 1'($urandom());
      v.vs  = 1'($urandom());
      v.r   = 8'($urandom());
      v.g   = 8'($urandom());
      v.b   = 8'($urandom());
      if (v.rst) begin
        m_cnt = '{0, 0, 0};
        v.e0 = 10'h354; v.e1 = 10'h354; v.e2 = 10'h354;
      end else begin
        model_enc(v.en & v.den, v.en ? {v.vs, v.hs} : 2'b00, v.b, m_cnt[0], s0);
        model_enc(v.en & v.den, 2'b00, v.g, m_cnt[1], s1);
        model_enc(v.en & v.den, 2'b00, v.r, m_cnt[2], s2);
        v.e0 = s0; v.e1 = s1; v.e2 = s2;
      end
      step(v);
    end

    check("cnt_bound_violations", 10'(cnt_viol), 10'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
